pl_skid_reg: RTL and testbench

PL_SKID_REG -- requirements
Module: pl_skid_reg

---
 rtl/pl_skid_reg_pkg.sv | 29 ++
 rtl/pl_skid_reg_dffe_ar.sv | 40 ++++
 rtl/pl_skid_reg.sv | 165 ++++++++++++++++
 tb/tb_pl_skid_reg.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pl_skid_reg_pkg
// Shared pipeline definitions for the skid register stage.
//
// Contents:
//   EMPTY / ONE / FULL  2-bit occupancy encodings. These equal the value seen on
//                       pl_skid_reg.count, so hazard and stall logic elsewhere
//                       in the pipeline can decode occupancy directly.
//   state_t             enumerated FSM state built on those encodings.
//   state_count()       maps a state to its occupancy count.
// -----------------------------------------------------------------------------
package pl_skid_reg_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = EMPTY,
        ST_ONE   = ONE,
        ST_FULL  = FULL
    } state_t;

    // The state encoding is the occupancy count. Encoding 3 is never reached.
    function automatic logic [1:0] state_count(input state_t s);
        return s;
    endfunction

endpackage

// File: rtl/pl_skid_reg_dffe_ar.sv
// -----------------------------------------------------------------------------
// pl_dffe_ar
// WIDTH-bit data register with asynchronous active-high reset, synchronous
// clear and a write enable. Clear has priority over the write enable, so a
// flush wins over any load requested in the same cycle.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset, forces q to 0
//   clr  in   synchronous clear, q <= 0 on the next edge
//   en   in   write enable, q <= d on the next edge
//   d    in   WIDTH-bit data in
//   q    out  WIDTH-bit registered data out
// -----------------------------------------------------------------------------
module pl_dffe_ar #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pl_skid_reg.sv
// -----------------------------------------------------------------------------
// pl_skid_reg
// Two-entry pipeline skid register with fully registered handshake outputs.
// in_ready and out_valid depend only on the FSM state, never combinationally on
// in_valid or out_ready. This breaks the ready/valid timing path between
// stages. The skid entry absorbs the one payload that can arrive in the cycle
// after downstream stalls.
//
// Parameters:
//   WIDTH       payload width in bits
//   CLEAR_DATA  1: flush zeroes both data registers; 0: flush leaves them alone
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous flush; wins over both handshakes
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage can accept a payload (state != FULL)
//   in_data    in   upstream payload
//   out_valid  out  stage presents out_data (state != EMPTY)
//   out_ready  in   downstream accepts out_data
//   out_data   out  payload at the head (the main register)
//   count      out  number of stored payloads, 0..2
// -----------------------------------------------------------------------------
module pl_skid_reg
    import pl_skid_reg_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    state_t           state_reg;
    state_t           state_next;

    logic             in_fire;
    logic             out_fire;

    logic             main_we;
    logic             main_from_skid;
    logic             skid_we;
    logic             data_clr;

    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Handshake outputs are decoded from the state register alone.
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_ready  = (state_reg != ST_FULL);
    assign count     = state_count(state_reg);

    assign in_fire   = in_valid  & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Data clearing on flush is a build-time choice. With CLEAR_DATA = 0 the
    // data registers simply see no write enable during a flush.
    assign data_clr  = flush & CLEAR_DATA;

    // The main register reloads from the skid entry when draining FULL and
    // from the upstream input in every other case.
    assign main_d    = main_from_skid ? skid_q : in_data;

    // ---------------------------------------------------------------------
    // Control FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM: next state and data-register enables
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        main_we        = 1'b0;
        main_from_skid = 1'b0;
        skid_we        = 1'b0;

        if (flush) begin
            // Flush overrides everything. A payload handed over in this
            // cycle is dropped because no write enable is raised.
            state_next = ST_EMPTY;
        end else begin
            unique case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_ONE;
                        main_we    = 1'b1;
                    end
                end

                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        // Head leaves while the new payload takes its place.
                        state_next = ST_ONE;
                        main_we    = 1'b1;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new payload behind.
                        state_next = ST_FULL;
                        skid_we    = 1'b1;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    // in_ready is low here, so only the drain matters.
                    if (out_fire) begin
                        state_next     = ST_ONE;
                        main_we        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end

                default: begin
                    // Encoding 3 cannot be reached. Recover to a clean state.
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Data storage
    // ---------------------------------------------------------------------
    pl_dffe_ar #(
        .WIDTH (WIDTH)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .clr (data_clr),
        .en  (main_we),
        .d   (main_d),
        .q   (main_q)
    );

    pl_dffe_ar #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (data_clr),
        .en  (skid_we),
        .d   (in_data),
        .q   (skid_q)
    );

    assign out_data = main_q;

endmodule

// File: tb/tb_pl_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pl_skid_reg
// Scoreboard bench for pl_skid_reg. Two instances share all inputs: one with
// CLEAR_DATA = 1 and one with CLEAR_DATA = 0.
//
// The reference model is a FIFO queue of stored payloads, capped at two
// entries. The driver pushes a payload when the model says it is accepted.
// The monitor checks on every falling edge and pops on each delivery.
// -----------------------------------------------------------------------------
module tb_pl_skid_reg;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;

    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    logic             in_ready_nc;
    logic             out_valid_nc;
    logic [WIDTH-1:0] out_data_nc;
    logic [1:0]       count_nc;

    pl_skid_reg #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    pl_skid_reg #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (1'b0)
    ) u_dut_nc (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_nc),
        .in_data   (in_data),
        .out_valid (out_valid_nc),
        .out_ready (out_ready),
        .out_data  (out_data_nc),
        .count     (count_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model state
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] sb[$];   // stored payloads, head first
    bit               pend;    // back entry accepted this cycle, not yet stored
    logic [WIDTH-1:0] hold1;   // out_data when empty, CLEAR_DATA = 1 instance
    logic [WIDTH-1:0] hold0;   // out_data when empty, CLEAR_DATA = 0 instance
    bit               mon_en;

    int checks = 0;
    int passes = 0;
    int n_delivered = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs. If the model says the payload is taken at
    // the next edge, push it to the scoreboard now.
    task automatic apply(input bit iv, input logic [WIDTH-1:0] d,
                         input bit orr, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        flush     = fl;
        pend      = 1'b0;
        if (iv && !fl && sb.size() < 2) begin
            sb.push_back(d);
            pend = 1'b1;
        end
    endtask

    task automatic drive(input bit iv, input logic [WIDTH-1:0] d,
                         input bit orr, input bit fl);
        @(posedge clk);
        #1;
        apply(iv, d, orr, fl);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " out_valid"},    32'(out_valid),    32'd0);
        chk({tag, " in_ready"},     32'(in_ready),     32'd1);
        chk({tag, " count"},        32'(count),        32'd0);
        chk({tag, " out_data"},     32'(out_data),     32'd0);
        chk({tag, " out_valid_nc"}, 32'(out_valid_nc), 32'd0);
        chk({tag, " in_ready_nc"},  32'(in_ready_nc),  32'd1);
        chk({tag, " count_nc"},     32'(count_nc),     32'd0);
        chk({tag, " out_data_nc"},  32'(out_data_nc),  32'd0);
    endtask

    // Assert reset between edges and check that the outputs respond before
    // the next edge. Then release reset and offer a payload at once. That
    // payload must be accepted on the first edge after release.
    task automatic do_reset_mid(input logic [WIDTH-1:0] first_word);
        @(posedge clk);
        #1;
        apply(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        hold1 = '0;
        hold0 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1'b1, first_word, 1'b1, 1'b0);
    endtask

    // ---------------------------------------------------------------------
    // Monitor: compare against the model on every falling edge, then update
    // the model for the edge that follows.
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        int n;
        logic [WIDTH-1:0] exp1;
        logic [WIDTH-1:0] exp0;
        if (mon_en && !rst) begin
            n    = sb.size() - int'(pend);
            exp1 = (n > 0) ? sb[0] : hold1;
            exp0 = (n > 0) ? sb[0] : hold0;

            chk("out_valid",    32'(out_valid),    32'(n > 0));
            chk("in_ready",     32'(in_ready),     32'(n < 2));
            chk("count",        32'(count),        32'(n));
            chk("out_data",     32'(out_data),     32'(exp1));
            chk("out_valid_nc", 32'(out_valid_nc), 32'(n > 0));
            chk("in_ready_nc",  32'(in_ready_nc),  32'(n < 2));
            chk("count_nc",     32'(count_nc),     32'(n));
            chk("out_data_nc",  32'(out_data_nc),  32'(exp0));

            if (flush) begin
                // Stored payloads are discarded. Without clearing, the main
                // register keeps showing the old head.
                if (n > 0) hold0 = sb[0];
                hold1 = '0;
                sb.delete();
                $display("flush: %0d payload(s) discarded", n);
            end else if (n > 0 && out_ready) begin
                $display("deliver #%0d: 0x%04h", n_delivered, sb[0]);
                n_delivered++;
                hold1 = sb[0];
                hold0 = sb[0];
                void'(sb.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        pend      = 1'b0;
        hold1     = '0;
        hold0     = '0;
        mon_en    = 1'b0;

        // Power-on reset, checked before any clock edge.
        #1;
        rst = 1'b1;
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Streaming at full rate.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, WIDTH'(k), 1'b1, 1'b0);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: fill to FULL, hold, then drain.
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 16'hBBBB, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Flush when FULL, with a payload offered in the same cycle.
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Flush in ONE while a handshake would otherwise accept 0x5555.
        drive(1'b1, 16'h4444, 1'b0, 1'b0);
        drive(1'b1, 16'h5555, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Flush retention on the CLEAR_DATA = 0 instance.
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Simultaneous accept and deliver in ONE.
        drive(1'b1, 16'h00FF, 1'b0, 1'b0);
        drive(1'b1, 16'h0F0F, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Reset asserted between edges, then an immediate transfer.
        do_reset_mid(16'hBEEF);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic. The first half is mostly ready and the second
        // half mostly stalled, so both ONE and FULL are visited often.
        for (int i = 0; i < 600; i++) begin
            bit               iv;
            bit               orr;
            bit               fl;
            logic [WIDTH-1:0] d;
            if (i == 300) begin
                do_reset_mid(WIDTH'($urandom));
            end else begin
                iv  = ($urandom_range(0, 3) != 0);
                d   = WIDTH'($urandom);
                orr = (i < 300) ? ($urandom_range(0, 3) != 0)
                                : ($urandom_range(0, 3) == 0);
                fl  = ($urandom_range(0, 49) == 0);
                drive(iv, d, orr, fl);
            end
        end

        // Drain.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
